// File: rtl/shared_bus_arbiter_pkg.sv
// shared_bus_arbiter_pkg: FSM state encoding and owner_id width for the shared bus arbiter
package shared_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam int OW = 3;

endpackage

// File: rtl/shared_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request strictly after ptr (wrapping)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int SW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [SW-1:0]   idx,
    output logic            any
);

    logic [SW-1:0] j;

    // Scan from farthest to nearest so the nearest requester after ptr is the last to write
    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            j = SW'((int'(ptr) + i) % NREQ);
            if (req[j]) begin
                win    = '0;
                win[j] = 1'b1;
                idx    = j;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter: round-robin time-sharing of one bus with a turnaround gap; ARB_PREEMPT_EN adds forced release after MAX_HOLD cycles
module shared_bus_arbiter
    import shared_bus_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
`ifdef ARB_PREEMPT_EN
    parameter int MAX_HOLD = 16,
`endif
    parameter int TA_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  wr,
    input  logic [NREQ*DW-1:0] drv_data,
    input  logic [DW-1:0]    bus_in,
    output logic [NREQ-1:0]  grant,
    output logic [OW-1:0]    owner_id,
    output logic             busy,
    output logic             bus_oe,
    output logic [DW-1:0]    bus_out,
    output logic [DW-1:0]    rd_data
);

    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TA_CYC + 1);

    state_t          state;
    logic [SW-1:0]   own;
    logic [SW-1:0]   ptr;
    logic [TW-1:0]   ta;
    logic [NREQ-1:0] win;
    logic [SW-1:0]   idx;
    logic            any;
    logic            arb;
    logic            exit_own;

    rr_pick #(.NREQ(NREQ), .SW(SW)) u_pick (
        .req(req),
        .ptr(ptr),
        .win(win),
        .idx(idx),
        .any(any)
    );

    // Arbitration happens from IDLE or on the last turnaround cycle
    assign arb      = (state != OWN) && (state != TURN || ta == TW'(TA_CYC - 1));
    assign busy     = state == OWN;
    assign owner_id = OW'(own);
    assign bus_oe   = busy & wr[own];
    assign bus_out  = bus_oe ? drv_data[int'(own)*DW +: DW] : '0;

`ifdef ARB_PREEMPT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold;

    // A dropped request and a preempt give the same exit
    assign exit_own = !req[own] || (hold == HW'(MAX_HOLD - 1) && |(req & ~grant));

    // Hold counter restarts on every grant and saturates while nobody else waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold <= '0;
        else if (arb)
            hold <= '0;
        else if (busy && hold != HW'(MAX_HOLD - 1))
            hold <= hold + 1'b1;
    end
`else
    assign exit_own = !req[own];
`endif

    // Ownership FSM: IDLE -> OWN -> TURN (TA_CYC cycles) -> OWN or IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            own   <= '0;
            ptr   <= SW'(NREQ - 1);
            ta    <= '0;
        end else if (arb) begin
            if (any) begin
                state <= OWN;
                grant <= win;
                own   <= idx;
                ptr   <= idx;
            end else begin
                state <= IDLE;
            end
        end else if (busy) begin
            if (exit_own) begin
                state <= TURN;
                grant <= '0;
                ta    <= '0;
            end
        end else begin
            ta <= ta + 1'b1;
        end
    end

    // Capture the bus on every cycle the owner is reading
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if (busy && !wr[own])
            rd_data <= bus_in;
    end

endmodule
